// File: rtl/simd_issue_ctrl_pkg.sv
// simd_issue_ctrl_pkg: opcode, ALU op, instruction class and FSM encodings plus instr field positions.
package simd_issue_ctrl_pkg;
   typedef enum logic [3:0] {
      OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
      OP_OR   = 4'h4, OP_XOR = 4'h5, OP_MOV = 4'h6, OP_LDI = 4'h7,
      OP_HALT = 4'hF
   } opcode_t;
   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_MOV} alu_op_t;
   typedef enum logic [2:0] {CLS_NOP, CLS_ALU, CLS_LDI, CLS_HALT, CLS_ILL} instr_class_t;
   typedef enum logic [2:0] {IDLE, DECODE, READ, EXEC, WAIT, WRITE, HALTED} state_t;
   localparam int OPC_LSB = 12;
   localparam int RD_LSB  = 8;
   localparam int RS1_LSB = 4;
   localparam int RS2_LSB = 0;
   localparam int IMM_LSB = 0;
endpackage

// File: rtl/simd_instr_decode.sv
// simd_instr_decode: maps a 4-bit opcode to its instruction class and ALU operation.
module simd_instr_decode
   import simd_issue_ctrl_pkg::*;
(
   input  logic [3:0]   opc,
   output instr_class_t cls,
   output alu_op_t      alu_op
);
   assign cls = (opc == OP_NOP)                   ? CLS_NOP  :
                (opc >= OP_ADD && opc <= OP_MOV)  ? CLS_ALU  :
                (opc == OP_LDI)                   ? CLS_LDI  :
                (opc == OP_HALT)                  ? CLS_HALT : CLS_ILL;
   assign alu_op = alu_op_t'(3'(opc - 4'd1));
endmodule

// File: rtl/simd_issue_ctrl.sv
// simd_issue_ctrl: single-issue controller sequencing register read, ALU issue, wait and write-back.
module simd_issue_ctrl
   import simd_issue_ctrl_pkg::*;
#(
   parameter int DW      = 8,
   parameter int AW      = 4,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [15:0]   instr,
   output logic          en_read,
   output logic [AW-1:0] reg_read_addr1,
   output logic [AW-1:0] reg_read_addr2,
   input  logic [DW-1:0] reg_read_data1,
   input  logic [DW-1:0] reg_read_data2,
   output logic          en_write,
   output logic [AW-1:0] reg_write_addr,
   output logic [DW-1:0] reg_write_data,
   output logic          alu_start,
   output logic [2:0]    alu_op,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   input  logic          alu_done,
   input  logic [DW-1:0] alu_result,
   output logic          busy,
   output logic          halted,
   output logic          err,
   output logic [15:0]   retired_cnt
);
   state_t       state;
   logic [15:0]  ir;
   logic [3:0]   timer;
   instr_class_t cls;
   alu_op_t      dec_op;

   simd_instr_decode u_dec (
      .opc    (ir[OPC_LSB +: 4]),
      .cls    (cls),
      .alu_op (dec_op)
   );

   // Outputs are registered alongside the state, so each is set on the edge entering its state.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state          <= IDLE;
         ir             <= '0;
         timer          <= '0;
         instr_ready    <= 1'b1;
         en_read        <= 1'b0;
         reg_read_addr1 <= '0;
         reg_read_addr2 <= '0;
         en_write       <= 1'b0;
         reg_write_addr <= '0;
         reg_write_data <= '0;
         alu_start      <= 1'b0;
         alu_op         <= '0;
         alu_a          <= '0;
         alu_b          <= '0;
         busy           <= 1'b0;
         halted         <= 1'b0;
         err            <= 1'b0;
         retired_cnt    <= '0;
      end else begin
         en_read   <= 1'b0;
         en_write  <= 1'b0;
         alu_start <= 1'b0;
         case (state)
            IDLE:
               if (instr_valid) begin
                  ir          <= instr;
                  instr_ready <= 1'b0;
                  busy        <= 1'b1;
                  state       <= DECODE;
               end
            DECODE:
               case (cls)
                  CLS_ALU: begin
                     en_read        <= 1'b1;
                     reg_read_addr1 <= AW'(ir[RS1_LSB +: 4]);
                     reg_read_addr2 <= AW'(ir[RS2_LSB +: 4]);
                     state          <= READ;
                  end
                  CLS_LDI: begin
                     en_write       <= 1'b1;
                     reg_write_addr <= AW'(ir[RD_LSB +: 4]);
                     reg_write_data <= DW'(ir[IMM_LSB +: 8]);
                     state          <= WRITE;
                  end
                  CLS_HALT: begin
                     halted <= 1'b1;
                     state  <= HALTED;
                  end
                  default: begin
                     err         <= err | (cls == CLS_ILL);
                     instr_ready <= 1'b1;
                     busy        <= 1'b0;
                     state       <= IDLE;
                  end
               endcase
            READ: begin
               alu_a     <= reg_read_data1;
               alu_b     <= reg_read_data2;
               alu_op    <= dec_op;
               alu_start <= 1'b1;
               state     <= EXEC;
            end
            EXEC: begin
               timer <= '0;
               state <= WAIT;
            end
            WAIT:
               if (alu_done) begin
                  en_write       <= 1'b1;
                  reg_write_addr <= AW'(ir[RD_LSB +: 4]);
                  reg_write_data <= alu_result;
                  state          <= WRITE;
               end else if (timer == 4'(TIMEOUT - 1)) begin
                  err         <= 1'b1;
                  instr_ready <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else
                  timer <= timer + 4'd1;
            WRITE: begin
               retired_cnt <= retired_cnt + 16'd1;
               instr_ready <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= HALTED;
         endcase
      end
endmodule

// File: tb/tb_simd_issue_ctrl.sv
// tb_simd_issue_ctrl: directed scenarios against a behavioural register file and hand-driven ALU.
module tb_simd_issue_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = '0;
   logic        en_read, en_write, alu_start, alu_done = 1'b0;
   logic [3:0]  reg_read_addr1, reg_read_addr2, reg_write_addr;
   logic [7:0]  reg_read_data1, reg_read_data2, reg_write_data;
   logic [2:0]  alu_op;
   logic [7:0]  alu_a, alu_b, alu_result = '0;
   logic        busy, halted, err;
   logic [15:0] retired_cnt;

   int n_chk = 0, n_fail = 0, wr_cnt = 0;
   bit overlap = 1'b0;
   logic [7:0]  rf [16] = '{default: 8'h00};
   logic [31:0] tr_rd, tr_st, tr_wr, tr_rdy, tr_err;
   logic [2:0]  op3;
   logic [7:0]  a3, b3;

   always #5 clk = ~clk;

   simd_issue_ctrl dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .en_read(en_read), .reg_read_addr1(reg_read_addr1), .reg_read_addr2(reg_read_addr2),
      .reg_read_data1(reg_read_data1), .reg_read_data2(reg_read_data2),
      .en_write(en_write), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
      .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_done(alu_done), .alu_result(alu_result),
      .busy(busy), .halted(halted), .err(err), .retired_cnt(retired_cnt)
   );

   assign reg_read_data1 = rf[reg_read_addr1];
   assign reg_read_data2 = rf[reg_read_addr2];

   always @(posedge clk)
      if (en_write) begin
         rf[reg_write_addr] <= reg_write_data;
         wr_cnt <= wr_cnt + 1;
      end

   always @(negedge clk) overlap <= overlap | (en_read & en_write);

   task automatic do_reset;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   // Cycle k of the trace is sampled on the negedge after the k-th rising edge past the handshake.
   task automatic exec_instr(input logic [15:0] i, input int done_at, input logic [7:0] res, input bit early);
      @(negedge clk); instr = i; instr_valid = 1'b1; alu_done = early; alu_result = res;
      @(posedge clk); #1 instr_valid = 1'b0; instr = '0;
      tr_rd = '0; tr_st = '0; tr_wr = '0; tr_rdy = '0; tr_err = '0;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         tr_rd[k] = en_read; tr_st[k] = alu_start; tr_wr[k] = en_write;
         tr_rdy[k] = instr_ready; tr_err[k] = err;
         if (k == 3) begin op3 = alu_op; a3 = alu_a; b3 = alu_b; end
         alu_done = (k == done_at) || (early && k < 4);
      end
      alu_done = 1'b0;
   endtask

   task automatic test_reset;
      n_chk++; if ({instr_ready, en_read, en_write, alu_start, busy, halted, err} !== 7'b1000000) begin n_fail++; $display("FAIL reset_status got %b want 1000000", {instr_ready, en_read, en_write, alu_start, busy, halted, err}); end
      n_chk++; if (retired_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_retired got %h want 0000", retired_cnt); end
      n_chk++; if ({reg_read_addr1, reg_read_addr2, reg_write_addr, reg_write_data, alu_op, alu_a, alu_b} !== 39'h0) begin n_fail++; $display("FAIL reset_addr_data got %h want 0", {reg_read_addr1, reg_read_addr2, reg_write_addr, reg_write_data, alu_op, alu_a, alu_b}); end
   endtask

   task automatic test_ldi_add;
      exec_instr(16'h735A, 0, 8'h00, 1'b0);
      n_chk++; if (tr_wr[3:1] !== 3'b010) begin n_fail++; $display("FAIL ldi_en_write trace got %b want 010", tr_wr[3:1]); end
      n_chk++; if (rf[3] !== 8'h5A) begin n_fail++; $display("FAIL ldi_r3 got %h want 5a", rf[3]); end
      exec_instr(16'h1433, 4, 8'hB4, 1'b0);
      n_chk++; if (tr_rd[6:1] !== 6'b000010) begin n_fail++; $display("FAIL add_en_read trace got %b want 000010", tr_rd[6:1]); end
      n_chk++; if (tr_st[6:1] !== 6'b000100) begin n_fail++; $display("FAIL add_alu_start trace got %b want 000100", tr_st[6:1]); end
      n_chk++; if (tr_wr !== 32'h20) begin n_fail++; $display("FAIL add_en_write trace got %h want 00000020", tr_wr); end
      n_chk++; if (tr_rdy[6:1] !== 6'b100000) begin n_fail++; $display("FAIL add_instr_ready trace got %b want 100000", tr_rdy[6:1]); end
      n_chk++; if ({op3, a3, b3} !== {3'd0, 8'h5A, 8'h5A}) begin n_fail++; $display("FAIL add_operands got %h/%h/%h want 0/5a/5a", op3, a3, b3); end
      n_chk++; if (rf[4] !== 8'hB4) begin n_fail++; $display("FAIL add_r4 got %h want b4", rf[4]); end
      n_chk++; if (retired_cnt !== 16'd2) begin n_fail++; $display("FAIL add_retired got %0d want 2", retired_cnt); end
   endtask

   task automatic test_done_ignored;
      exec_instr(16'h710F, 0, 8'h00, 1'b0);
      exec_instr(16'h72F0, 0, 8'h00, 1'b0);
      exec_instr(16'h5512, 6, 8'hFF, 1'b1);
      n_chk++; if ({op3, a3, b3} !== {3'd4, 8'h0F, 8'hF0}) begin n_fail++; $display("FAIL xor_operands got %h/%h/%h want 4/0f/f0", op3, a3, b3); end
      n_chk++; if (tr_wr !== 32'h80) begin n_fail++; $display("FAIL xor_early_done_en_write got %h want 00000080", tr_wr); end
      n_chk++; if (rf[5] !== 8'hFF) begin n_fail++; $display("FAIL xor_r5 got %h want ff", rf[5]); end
      n_chk++; if (retired_cnt !== 16'd5) begin n_fail++; $display("FAIL xor_retired got %0d want 5", retired_cnt); end
      n_chk++; if (overlap !== 1'b0) begin n_fail++; $display("FAIL read_write_overlap got %b want 0", overlap); end
   endtask

   task automatic test_illegal;
      do_reset();
      exec_instr(16'hA000, 0, 8'h00, 1'b0);
      n_chk++; if (tr_err[2:1] !== 2'b10) begin n_fail++; $display("FAIL illegal_err trace got %b want 10", tr_err[2:1]); end
      n_chk++; if (tr_rdy[2:1] !== 2'b10) begin n_fail++; $display("FAIL illegal_ready trace got %b want 10", tr_rdy[2:1]); end
      n_chk++; if (tr_wr !== 32'h0) begin n_fail++; $display("FAIL illegal_no_write got %h want 0", tr_wr); end
      exec_instr(16'h773C, 0, 8'h00, 1'b0);
      n_chk++; if (rf[7] !== 8'h3C) begin n_fail++; $display("FAIL illegal_then_ldi_r7 got %h want 3c", rf[7]); end
      n_chk++; if ({retired_cnt, err} !== {16'd1, 1'b1}) begin n_fail++; $display("FAIL illegal_then_ldi_status got %0d/%b want 1/1", retired_cnt, err); end
   endtask

   task automatic test_timeout;
      int w0;
      do_reset();
      w0 = wr_cnt;
      exec_instr(16'h2612, 0, 8'h00, 1'b0);
      n_chk++; if (tr_err[19:18] !== 2'b10) begin n_fail++; $display("FAIL timeout_err cycle18/19 got %b want 10", tr_err[19:18]); end
      n_chk++; if (tr_rdy[19:18] !== 2'b10) begin n_fail++; $display("FAIL timeout_ready cycle18/19 got %b want 10", tr_rdy[19:18]); end
      n_chk++; if (wr_cnt - w0 !== 0 || tr_wr !== 32'h0) begin n_fail++; $display("FAIL timeout_no_write got %0d writes want 0", wr_cnt - w0); end
      n_chk++; if ({retired_cnt, busy} !== 17'h0) begin n_fail++; $display("FAIL timeout_idle got %0d/%b want 0/0", retired_cnt, busy); end
   endtask

   task automatic test_halt;
      @(negedge clk); instr = 16'hF000; instr_valid = 1'b1;
      repeat (4) @(negedge clk);
      n_chk++; if ({halted, instr_ready, busy, en_read, en_write, alu_start} !== 6'b101000) begin n_fail++; $display("FAIL halt_status got %b want 101000", {halted, instr_ready, busy, en_read, en_write, alu_start}); end
      repeat (4) @(negedge clk);
      n_chk++; if ({halted, instr_ready} !== 2'b10) begin n_fail++; $display("FAIL halt_sticky got %b want 10", {halted, instr_ready}); end
      #2 rst_n = 1'b0; #1;
      n_chk++; if ({halted, instr_ready, busy, err} !== 4'b0100) begin n_fail++; $display("FAIL halt_async_reset got %b want 0100", {halted, instr_ready, busy, err}); end
      instr_valid = 1'b0; instr = '0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_chk++; if ({halted, instr_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL halt_after_reset got %b want 010", {halted, instr_ready, busy}); end
   endtask

   task automatic test_reset_in_wait;
      int w0;
      w0 = wr_cnt;
      @(negedge clk); instr = 16'h1811; instr_valid = 1'b1; alu_done = 1'b0;
      @(posedge clk); #1 instr_valid = 1'b0; instr = '0;
      repeat (5) @(negedge clk);
      n_chk++; if ({busy, instr_ready} !== 2'b10) begin n_fail++; $display("FAIL wait_busy got %b want 10", {busy, instr_ready}); end
      #2 rst_n = 1'b0; #1;
      n_chk++; if ({instr_ready, en_read, en_write, alu_start, busy, halted, err} !== 7'b1000000) begin n_fail++; $display("FAIL wait_async_reset got %b want 1000000", {instr_ready, en_read, en_write, alu_start, busy, halted, err}); end
      n_chk++; if ({reg_read_addr1, reg_read_addr2, alu_a, alu_b, retired_cnt} !== 40'h0) begin n_fail++; $display("FAIL wait_reset_outputs got %h want 0", {reg_read_addr1, reg_read_addr2, alu_a, alu_b, retired_cnt}); end
      repeat (2) @(negedge clk); alu_done = 1'b1; alu_result = 8'h99;
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk); alu_done = 1'b0;
      n_chk++; if (wr_cnt - w0 !== 0 || rf[8] !== 8'h00) begin n_fail++; $display("FAIL wait_reset_no_write got %0d writes r8=%h want 0/00", wr_cnt - w0, rf[8]); end
   endtask

   task automatic test_wrap;
      @(negedge clk); force dut.retired_cnt = 16'hFFFF;
      @(negedge clk); release dut.retired_cnt;
      @(negedge clk);
      n_chk++; if (retired_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preset got %h want ffff", retired_cnt); end
      exec_instr(16'h7901, 0, 8'h00, 1'b0);
      n_chk++; if (retired_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_retired got %h want 0000", retired_cnt); end
      n_chk++; if (rf[9] !== 8'h01) begin n_fail++; $display("FAIL wrap_r9 got %h want 01", rf[9]); end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      test_ldi_add();
      test_done_ignored();
      test_illegal();
      test_timeout();
      test_halt();
      test_reset_in_wait();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1, "watchdog");
   end
endmodule
